// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and decode helper for the sequential ALU.
package alu_seq_pkg;

  localparam logic [5:0] OP_ADD    = 6'b000000;
  localparam logic [5:0] OP_ADDCC  = 6'b010000;
  localparam logic [5:0] OP_ADDX   = 6'b001000;
  localparam logic [5:0] OP_ADDXCC = 6'b011000;
  localparam logic [5:0] OP_SUB    = 6'b000100;
  localparam logic [5:0] OP_SUBCC  = 6'b010100;
  localparam logic [5:0] OP_SUBX   = 6'b001100;
  localparam logic [5:0] OP_SUBXCC = 6'b011100;
  localparam logic [5:0] OP_AND    = 6'b000001;
  localparam logic [5:0] OP_ANDCC  = 6'b010001;
  localparam logic [5:0] OP_NAND   = 6'b000101;
  localparam logic [5:0] OP_NANDCC = 6'b010101;
  localparam logic [5:0] OP_OR     = 6'b000010;
  localparam logic [5:0] OP_ORCC   = 6'b010010;
  localparam logic [5:0] OP_NOR    = 6'b000110;
  localparam logic [5:0] OP_NORCC  = 6'b010110;
  localparam logic [5:0] OP_XOR    = 6'b000011;
  localparam logic [5:0] OP_XORCC  = 6'b010011;
  localparam logic [5:0] OP_XNOR   = 6'b000111;
  localparam logic [5:0] OP_XNORCC = 6'b010111;
  localparam logic [5:0] OP_SLL    = 6'b100101;
  localparam logic [5:0] OP_SRL    = 6'b100110;
  localparam logic [5:0] OP_SRA    = 6'b100111;
  localparam logic [5:0] OP_SETHI  = 6'b101010;
  localparam logic [5:0] OP_UMUL   = 6'b001010;
  localparam logic [5:0] OP_SMUL   = 6'b001011;
  localparam logic [5:0] OP_UMULCC = 6'b011010;
  localparam logic [5:0] OP_SMULCC = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_cc(input logic [5:0] opcode);
    return opcode[4];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result bus between the register-read stage, the ALU and writeback.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] Y;
  logic             N;
  logic             Z;
  logic             V;
  logic             C;
  logic             illegal;

  modport master (
    output in_valid, opcode, A_in, B_in,
    input  in_ready, out_valid, result, Y, N, Z, V, C, illegal
  );

  modport slave (
    input  in_valid, opcode, A_in, B_in,
    output in_ready, out_valid, result, Y, N, Z, V, C, illegal
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Only present when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_seq_mul #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  logic                busy;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH-1:0]  mcand;
  logic [2*WIDTH-1:0]  acc;
  logic [2*WIDTH-1:0]  acc_nxt;
  logic [WIDTH-1:0]    mplier;

  // product is the accumulator after this cycle's step, so it is final while done is high
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule
`endif

// File: rtl/alu_seq.sv
// Clocked SPARC integer ALU with internal icc; single-cycle ops at latency 1.
// Define ALU_SEQ_MUL_EN to build the iterative UMUL/SMUL path and the Y register.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  logic                    in_ready;
  logic                    accept;
  logic                    mul_op;
  logic                    cin;
  logic [WIDTH:0]          ext;
  logic signed [WIDTH-1:0] a_s;
  logic [SHW-1:0]          shamt;
  logic [WIDTH-1:0]        res_nxt;
  logic                    set_nz;
  logic                    n_nxt, z_nxt, v_nxt, c_nxt;
  logic                    ill_nxt;
  logic                    mul_fin;
  logic                    mul_fin_cc;
  logic [WIDTH-1:0]        mul_lo;

  logic [WIDTH-1:0]        result_p1;
  logic                    vld_p1;
  logic                    illegal_p1;
  logic                    icc_n, icc_z, icc_v, icc_c;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  assign a_s    = bus.A_in;
  assign shamt  = bus.B_in[SHW-1:0];
  assign cin    = bus.opcode[3] & icc_c;
  assign accept = bus.in_valid & in_ready;

  always_comb begin
    res_nxt = '0;
    ext     = '0;
    set_nz  = 1'b0;
    n_nxt   = icc_n;
    z_nxt   = icc_z;
    v_nxt   = icc_v;
    c_nxt   = icc_c;
    ill_nxt = 1'b0;
    mul_op  = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_ADDCC, OP_ADDX, OP_ADDXCC: begin
        ext     = {1'b0, bus.A_in} + {1'b0, bus.B_in} + {{WIDTH{1'b0}}, cin};
        res_nxt = ext[WIDTH-1:0];
        if (is_cc(bus.opcode)) begin
          set_nz = 1'b1;
          v_nxt  = add_ovf(bus.A_in[MSB], bus.B_in[MSB], ext[MSB]);
          c_nxt  = ext[WIDTH];
        end
      end
      OP_SUB, OP_SUBCC, OP_SUBX, OP_SUBXCC: begin
        // bit WIDTH of the extended difference is the borrow, carry-in included
        ext     = {1'b0, bus.A_in} - {1'b0, bus.B_in} - {{WIDTH{1'b0}}, cin};
        res_nxt = ext[WIDTH-1:0];
        if (is_cc(bus.opcode)) begin
          set_nz = 1'b1;
          v_nxt  = sub_ovf(bus.A_in[MSB], bus.B_in[MSB], ext[MSB]);
          c_nxt  = ext[WIDTH];
        end
      end
      OP_AND,  OP_ANDCC:  res_nxt = bus.A_in & bus.B_in;
      OP_NAND, OP_NANDCC: res_nxt = ~(bus.A_in & bus.B_in);
      OP_OR,   OP_ORCC:   res_nxt = bus.A_in | bus.B_in;
      OP_NOR,  OP_NORCC:  res_nxt = ~(bus.A_in | bus.B_in);
      OP_XOR,  OP_XORCC:  res_nxt = bus.A_in ^ bus.B_in;
      OP_XNOR, OP_XNORCC: res_nxt = ~(bus.A_in ^ bus.B_in);
      OP_SLL:             res_nxt = bus.A_in << shamt;
      OP_SRL:             res_nxt = bus.A_in >> shamt;
      OP_SRA:             res_nxt = a_s >>> shamt;
      OP_SETHI:           res_nxt = bus.B_in << 10;
`ifdef ALU_SEQ_MUL_EN
      OP_UMUL, OP_SMUL, OP_UMULCC, OP_SMULCC: mul_op = 1'b1;
`endif
      default:            ill_nxt = 1'b1;
    endcase
    // logic cc forms clear V and C; arithmetic cc forms set them above
    if (is_cc(bus.opcode) && !ill_nxt && !mul_op && (bus.opcode[1:0] != 2'b00)) begin
      set_nz = 1'b1;
      v_nxt  = 1'b0;
      c_nxt  = 1'b0;
    end
    if (set_nz) begin
      n_nxt = res_nxt[MSB];
      z_nxt = (res_nxt == '0);
    end
  end

`ifdef ALU_SEQ_MUL_EN
  state_t             state_q;
  state_t             state_nxt;
  logic               smul;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_cc_p0;
  logic               mul_neg_p0;
  logic [WIDTH-1:0]   y_p1;

  // SMUL multiplies magnitudes and fixes the sign on the full 2W-bit product
  assign smul  = bus.opcode[0];
  assign mag_a = (smul && bus.A_in[MSB]) ? (~bus.A_in + 1'b1) : bus.A_in;
  assign mag_b = (smul && bus.B_in[MSB]) ? (~bus.B_in + 1'b1) : bus.B_in;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (accept && mul_op) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)         state_nxt = ST_DONE;
      ST_DONE:                       state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept & mul_op),
    .a       (mag_a),
    .b       (mag_b),
    .done    (mul_done),
    .product (prod_raw)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      mul_cc_p0  <= is_cc(bus.opcode);
      mul_neg_p0 <= smul & (bus.A_in[MSB] ^ bus.B_in[MSB]);
    end
  end

  assign mul_prod   = mul_neg_p0 ? (~prod_raw + 1'b1) : prod_raw;
  assign mul_fin    = (state_q == ST_MUL) & mul_done;
  assign mul_fin_cc = mul_cc_p0;
  assign mul_lo     = mul_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset)        y_p1 <= '0;
    else if (mul_fin) y_p1 <= mul_prod[2*WIDTH-1:WIDTH];
  end

  assign bus.Y = y_p1;
`else
  assign in_ready   = 1'b1;
  assign mul_fin    = 1'b0;
  assign mul_fin_cc = 1'b0;
  assign mul_lo     = '0;
  assign bus.Y      = '0;
`endif

  // ---- result / icc register stage (p1) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      result_p1  <= '0;
      icc_n      <= 1'b0;
      icc_z      <= 1'b0;
      icc_v      <= 1'b0;
      icc_c      <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      if (accept && !mul_op) begin
        vld_p1     <= 1'b1;
        illegal_p1 <= ill_nxt;
        result_p1  <= res_nxt;
        icc_n      <= n_nxt;
        icc_z      <= z_nxt;
        icc_v      <= v_nxt;
        icc_c      <= c_nxt;
      end else if (mul_fin) begin
        vld_p1    <= 1'b1;
        result_p1 <= mul_lo;
        if (mul_fin_cc) begin
          icc_n <= mul_lo[MSB];
          icc_z <= (mul_lo == '0);
          icc_v <= 1'b0;
          icc_c <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.illegal   = illegal_p1;
  assign bus.result    = result_p1;
  assign bus.N         = icc_n;
  assign bus.Z         = icc_z;
  assign bus.V         = icc_v;
  assign bus.C         = icc_c;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected responses, a monitor pops on out_valid.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] y;
    logic [3:0]  nzvc;
    logic        ill;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every out_valid must match the oldest outstanding expectation, on its due cycle
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid cyc=%0d result=%h ill=%b, required no output", cyc, bus.result, bus.illegal);
      end else begin
        e = sbq.pop_front();
        if (bus.result !== e.res || bus.Y !== e.y || {bus.N, bus.Z, bus.V, bus.C} !== e.nzvc ||
            bus.illegal !== e.ill || cyc != e.due) begin
          n_fail++;
          $display("FAIL %s got res=%h y=%h nzvc=%b ill=%b cyc=%0d, required res=%h y=%h nzvc=%b ill=%b cyc=%0d",
                   e.name, bus.result, bus.Y, {bus.N, bus.Z, bus.V, bus.C}, bus.illegal, cyc,
                   e.res, e.y, e.nzvc, e.ill, e.due);
        end
      end
    end
  end

  task automatic issue(input string name, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] ey, input logic [3:0] enzvc,
                       input logic eill, input int lat, input bit expect_out);
    int waitn = 0;
    exp_t x;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.A_in     = a;
    bus.B_in     = b;
    while (bus.in_ready !== 1'b1 && waitn < 100) begin
      @(negedge clk);
      waitn++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_issue_timeout in_ready=%b, required 1", name, bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    if (expect_out) begin
      x.name = name; x.res = er; x.y = ey; x.nzvc = enzvc; x.ill = eill; x.due = cyc + lat;
      sbq.push_back(x);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [31:0] er, input logic [31:0] ey, input logic [3:0] enzvc);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.illegal !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== er ||
        bus.Y !== ey || {bus.N, bus.Z, bus.V, bus.C} !== enzvc) begin
      n_fail++;
      $display("FAIL %s got vld=%b ill=%b rdy=%b res=%h y=%h nzvc=%b, required vld=0 ill=0 rdy=1 res=%h y=%h nzvc=%b",
               name, bus.out_valid, bus.illegal, bus.in_ready, bus.result, bus.Y, {bus.N, bus.Z, bus.V, bus.C},
               er, ey, enzvc);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout outstanding=%0d, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_bad;
    int ov_seen;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.opcode   = '0;
    bus.A_in     = '0;
    bus.B_in     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_state("reset", 32'h0, 32'h0, 4'b0000);

    // arithmetic, carry chaining and flag retention (back-to-back issue)
    issue("addcc_ovf",  OP_ADDCC,  32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0, 4'b1010, 1'b0, 1, 1);
    issue("addcc_wrap", OP_ADDCC,  32'hFFFFFFFF, 32'h1,        32'h00000000, 32'h0, 4'b0101, 1'b0, 1, 1);
    issue("addx_cin",   OP_ADDX,   32'h5,        32'h6,        32'h0000000C, 32'h0, 4'b0101, 1'b0, 1, 1);
    issue("subcc_neg",  OP_SUBCC,  32'h3,        32'h5,        32'hFFFFFFFE, 32'h0, 4'b1001, 1'b0, 1, 1);
    issue("sub_nocc",   OP_SUB,    32'hA,        32'h4,        32'h00000006, 32'h0, 4'b1001, 1'b0, 1, 1);
    issue("subxcc_c1",  OP_SUBXCC, 32'hA,        32'h4,        32'h00000005, 32'h0, 4'b0000, 1'b0, 1, 1);
    idle();
    issue("subcc_0m1",  OP_SUBCC,  32'h0,        32'h1,        32'hFFFFFFFF, 32'h0, 4'b1001, 1'b0, 1, 1);
    issue("subxcc_brw", OP_SUBXCC, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0, 4'b1001, 1'b0, 1, 1);
    issue("addxcc_c1",  OP_ADDXCC, 32'h1,        32'h2,        32'h00000004, 32'h0, 4'b0000, 1'b0, 1, 1);
    issue("subcc_ovf",  OP_SUBCC,  32'h80000000, 32'h1,        32'h7FFFFFFF, 32'h0, 4'b0010, 1'b0, 1, 1);
    issue("addcc_min2", OP_ADDCC,  32'h80000000, 32'h80000000, 32'h00000000, 32'h0, 4'b0111, 1'b0, 1, 1);
    idle();
    // logic ops
    issue("andcc",      OP_ANDCC,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 4'b1000, 1'b0, 1, 1);
    issue("xorcc_zero", OP_XORCC,  32'h1234,     32'h1234,     32'h00000000, 32'h0, 4'b0100, 1'b0, 1, 1);
    issue("norcc",      OP_NORCC,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h0, 4'b1000, 1'b0, 1, 1);
    issue("nand_nocc",  OP_NAND,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 4'b1000, 1'b0, 1, 1);
    issue("xnorcc",     OP_XNORCC, 32'hAAAA5555, 32'h5555AAAA, 32'h00000000, 32'h0, 4'b0100, 1'b0, 1, 1);
    issue("or_nocc",    OP_OR,     32'h1,        32'h2,        32'h00000003, 32'h0, 4'b0100, 1'b0, 1, 1);
    issue("nandcc",     OP_NANDCC, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0, 4'b1000, 1'b0, 1, 1);
    // shifts and SETHI
    issue("sra_mod",    OP_SRA,    32'h80000000, 32'h21,       32'hC0000000, 32'h0, 4'b1000, 1'b0, 1, 1);
    issue("sll_31",     OP_SLL,    32'h1,        32'h1F,       32'h80000000, 32'h0, 4'b1000, 1'b0, 1, 1);
    issue("srl_4",      OP_SRL,    32'h80000000, 32'h4,        32'h08000000, 32'h0, 4'b1000, 1'b0, 1, 1);
    issue("sll_amt0",   OP_SLL,    32'h1234,     32'h20,       32'h00001234, 32'h0, 4'b1000, 1'b0, 1, 1);
    issue("sra_pos31",  OP_SRA,    32'h7FFFFFFF, 32'h1F,       32'h00000000, 32'h0, 4'b1000, 1'b0, 1, 1);
    issue("sethi",      OP_SETHI,  32'h0,        32'h3FFFFF,   32'hFFFFFC00, 32'h0, 4'b1000, 1'b0, 1, 1);
    issue("illegal_3f", 6'b111111, 32'h1,        32'h1,        32'h00000000, 32'h0, 4'b1000, 1'b1, 1, 1);
    idle();

`ifdef ALU_SEQ_MUL_EN
    issue("smulcc_m3x7", OP_SMULCC, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1000, 1'b0, W + 1, 1);
    idle();
    rdy_bad = 0;
    for (int i = 0; i < W + 1; i++) begin
      if (bus.in_ready !== 1'b0) rdy_bad++;
      if (i < W) @(negedge clk);
    end
    n_checks++;
    if (rdy_bad != 0) begin
      n_fail++;
      $display("FAIL mul_in_ready_low got %0d cycles with in_ready!=0, required 0", rdy_bad);
    end
    issue("umul_max",    OP_UMUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 1'b0, W + 1, 1);
    issue("umulcc_2p32", OP_UMULCC, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 4'b0100, 1'b0, W + 1, 1);
    issue("smul_minmin", OP_SMUL,   32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 4'b0100, 1'b0, W + 1, 1);
    issue("smul_5xm2",   OP_SMUL,   32'h5,        32'hFFFFFFFE, 32'hFFFFFFF6, 32'hFFFFFFFF, 4'b0100, 1'b0, W + 1, 1);
    issue("addcc_after", OP_ADDCC,  32'h1,        32'h1,        32'h00000002, 32'hFFFFFFFF, 4'b0000, 1'b0, 1, 1);
    issue("illegal_y",   6'b111111, 32'h0,        32'h0,        32'h00000000, 32'hFFFFFFFF, 4'b0000, 1'b1, 1, 1);
    idle();
    drain();
    // reset ten cycles into a multiply aborts it
    issue("smulcc_abort", OP_SMULCC, 32'hFFFFFFFD, 32'h7, 32'h0, 32'h0, 4'b0000, 1'b0, W + 1, 0);
    idle();
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_state("mul_abort_reset", 32'h0, 32'h0, 4'b0000);
    ov_seen = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ov_seen++;
    end
    n_checks++;
    if (ov_seen != 0) begin
      n_fail++;
      $display("FAIL mul_abort_no_output got %0d out_valid pulses, required 0", ov_seen);
    end
`else
    issue("umul_illegal",   OP_UMUL,   32'h10, 32'h10, 32'h0, 32'h0, 4'b1000, 1'b1, 1, 1);
    issue("smulcc_illegal", OP_SMULCC, 32'h3,  32'h7,  32'h0, 32'h0, 4'b1000, 1'b1, 1, 1);
    idle();
    drain();
`endif

    // reset asserted together with in_valid: nothing is accepted
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.opcode   = OP_ADDCC;
    bus.A_in     = 32'h7FFFFFFF;
    bus.B_in     = 32'h1;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check_state("reset_wins", 32'h0, 32'h0, 4'b0000);
    @(negedge clk);
    check_state("reset_wins_after", 32'h0, 32'h0, 4'b0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
